// File: rtl/slice_debounce_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : slice_debounce_array
// Brief    : NUM_CH clocked hysteretic slicers with debounce and saturating
//            rising-edge counters. Define SLICE_MAJORITY_EN for majority filter.
// Revision : 1.0 - initial release
// ============================================================================
module slice_debounce_array #(
    parameter int  NUM_CH    = 4,
    parameter real THRESHOLD = 0.0,
    parameter real HYST      = 0.1,
    parameter int  DEB_LEN   = 3,
    parameter int  CNT_W     = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           clr_cnt,
    input  real                            in [NUM_CH],
    input  real                            in_ref,
    output logic [NUM_CH-1:0]              raw,
    output logic [NUM_CH-1:0]              out,
    output logic [NUM_CH-1:0][CNT_W-1:0]   rise_cnt,
    output logic                           valid
);

    localparam int                 c_DEB_W    = $clog2(DEB_LEN + 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_LEN);
    localparam real                c_HALF     = HYST / 2.0;
    localparam bit                 c_NO_HYST  = (HYST == 0.0);
    localparam logic [CNT_W-1:0]   c_CNT_MAX  = {CNT_W{1'b1}};

    logic [NUM_CH-1:0]            r_raw;
    logic [NUM_CH-1:0]            r_out;
    logic [NUM_CH-1:0][CNT_W-1:0] r_rise;
    logic [c_DEB_W-1:0]           r_warm;
    logic                         r_valid;

    real                          w_d [NUM_CH];
    logic [NUM_CH-1:0]            w_raw_nxt;
    logic [NUM_CH-1:0]            w_out_nxt;
    logic [NUM_CH-1:0]            w_rise;
    logic [c_DEB_W-1:0]           w_warm_inc;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_d[i] = in[i] - (in_ref + THRESHOLD);
            // Zero window degenerates to a strict compare so d == 0 slices low
            if (c_NO_HYST)
                w_raw_nxt[i] = (w_d[i] > 0.0);
            else if (r_raw[i])
                w_raw_nxt[i] = !(w_d[i] < -c_HALF);
            else
                w_raw_nxt[i] = (w_d[i] > c_HALF);
        end
    end

`ifdef SLICE_MAJORITY_EN
    logic [DEB_LEN-1:0] r_hist     [NUM_CH];
    logic [DEB_LEN-1:0] w_hist_nxt [NUM_CH];

    if (DEB_LEN % 2 == 0) begin : g_even_deb_len
        $error("slice_debounce_array: DEB_LEN must be odd for majority filtering");
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_hist_nxt[i] = (r_hist[i] << 1) | DEB_LEN'(w_raw_nxt[i]);
            w_out_nxt[i]  = ($countones(w_hist_nxt[i]) > (DEB_LEN / 2));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst)
                r_hist[i] <= '0;
            else if (en)
                r_hist[i] <= w_hist_nxt[i];
        end
    end
`else
    logic [c_DEB_W-1:0] r_deb     [NUM_CH];
    logic [c_DEB_W-1:0] w_deb_nxt [NUM_CH];
    logic [c_DEB_W-1:0] w_deb_inc [NUM_CH];

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_deb_inc[i] = r_deb[i] + 1'b1;
            w_deb_nxt[i] = '0;
            w_out_nxt[i] = r_out[i];
            // Any agreeing sample restarts the run; a full run flips out
            if (w_raw_nxt[i] != r_out[i]) begin
                if (w_deb_inc[i] == c_DEB_LAST)
                    w_out_nxt[i] = ~r_out[i];
                else
                    w_deb_nxt[i] = w_deb_inc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst)
                r_deb[i] <= '0;
            else if (en)
                r_deb[i] <= w_deb_nxt[i];
        end
    end
`endif

    assign w_rise     = en ? (w_out_nxt & ~r_out) : '0;
    assign w_warm_inc = r_warm + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw   <= '0;
            r_out   <= '0;
            r_rise  <= '0;
            r_warm  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (en) begin
                r_raw <= w_raw_nxt;
                r_out <= w_out_nxt;
                if (!r_valid) begin
                    r_warm <= w_warm_inc;
                    if (w_warm_inc == c_DEB_LAST)
                        r_valid <= 1'b1;
                end
            end
            // A rise coincident with clear is kept as the first new count
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr_cnt)
                    r_rise[i] <= CNT_W'(w_rise[i]);
                else if (w_rise[i] && (r_rise[i] != c_CNT_MAX))
                    r_rise[i] <= r_rise[i] + 1'b1;
            end
        end
    end

    assign raw      = r_raw;
    assign out      = r_out;
    assign rise_cnt = r_rise;
    assign valid    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_slice_debounce_array.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for slice_debounce_array: two instances (default, and HYST=0.2/CNT_W=2)
// checked every cycle against a sample-history model plus literal expectations.
module tb_slice_debounce_array;

    localparam int DEB = 3;

    logic clk = 1'b0;
    logic rst, en, clr;
    real  in_v [4];
    real  ref_v;

    logic [3:0]       raw_a, out_a, raw_b, out_b;
    logic [3:0][7:0]  rc_a;
    logic [3:0][1:0]  rc_b;
    logic             valid_a, valid_b;

    int checks   = 0;
    int failures = 0;

    always #0.5 clk = ~clk;

    slice_debounce_array #(.NUM_CH(4), .THRESHOLD(0.0), .HYST(0.1), .DEB_LEN(DEB), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr), .in(in_v), .in_ref(ref_v),
        .raw(raw_a), .out(out_a), .rise_cnt(rc_a), .valid(valid_a));

    slice_debounce_array #(.NUM_CH(4), .THRESHOLD(0.0), .HYST(0.2), .DEB_LEN(DEB), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .clr_cnt(clr), .in(in_v), .in_ref(ref_v),
        .raw(raw_b), .out(out_b), .rise_cnt(rc_b), .valid(valid_b));

    // Model: out flips once DEB consecutive enabled samples all disagree with it
    real hyst_m [2] = '{0.1, 0.2};
    int  cmax_m [2] = '{255, 3};
    bit  m_raw [2][4];
    bit  m_out [2][4];
    int  m_rc  [2][4];
    int  m_last[2][4];
    int  m_n   [2];
    bit  m_valid [2];
    bit  m_live = 1'b0;
    real dv;
    bit  rise;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_n[d] = 0;
                m_valid[d] = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    m_raw[d][c] = 1'b0; m_out[d][c] = 1'b0;
                    m_rc[d][c] = 0;     m_last[d][c] = 0;
                end
            end else begin
                if (en) m_n[d]++;
                m_valid[d] = (m_n[d] >= DEB);
                for (int c = 0; c < 4; c++) begin
                    rise = 1'b0;
                    if (en) begin
                        dv = in_v[c] - ref_v;
                        if (dv > hyst_m[d] / 2.0)       m_raw[d][c] = 1'b1;
                        else if (dv < -hyst_m[d] / 2.0) m_raw[d][c] = 1'b0;
                        if (m_raw[d][c] == m_out[d][c]) m_last[d][c] = m_n[d];
                        else if (m_n[d] - m_last[d][c] >= DEB) begin
                            m_out[d][c]  = m_raw[d][c];
                            m_last[d][c] = m_n[d];
                            rise = m_out[d][c];
                        end
                    end
                    if (clr) m_rc[d][c] = int'(rise);
                    else if (rise && m_rc[d][c] < cmax_m[d]) m_rc[d][c]++;
                end
            end
        end
        m_live = 1'b1;
    end

    task automatic chk(input string nm, input int d, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d ch%0d actual=%0d required=%0d", nm, d, c, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #0.1;
        if (m_live) begin
            chk("valid", 0, 0, int'(valid_a), int'(m_valid[0]));
            chk("valid", 1, 0, int'(valid_b), int'(m_valid[1]));
            for (int c = 0; c < 4; c++) begin
                chk("raw",      0, c, int'(raw_a[c]), int'(m_raw[0][c]));
                chk("out",      0, c, int'(out_a[c]), int'(m_out[0][c]));
                chk("rise_cnt", 0, c, int'(rc_a[c]),  m_rc[0][c]);
                chk("raw",      1, c, int'(raw_b[c]), int'(m_raw[1][c]));
                chk("out",      1, c, int'(out_b[c]), int'(m_out[1][c]));
                chk("rise_cnt", 1, c, int'(rc_b[c]),  m_rc[1][c]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #0.3;
        end
    endtask

    task automatic set_all(input real v);
        for (int c = 0; c < 4; c++) in_v[c] = v;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0; ref_v = 0.0;
        set_all(0.0);

        // Reset and warm-up of valid
        tick(2);
        chk("lit_rst_valid", 0, 0, int'(valid_a), 0);
        chk("lit_rst_out",   0, 0, int'(out_a), 0);
        chk("lit_rst_rcnt",  0, 0, int'(rc_a[0]), 0);
        rst = 1'b0;
        tick(2);
        chk("lit_valid_e2", 0, 0, int'(valid_a), 0);
        tick(1);
        chk("lit_valid_e3", 0, 0, int'(valid_a), 1);

        // 100 MHz sine on ch0 sampled at 1 GHz: one out rise per 10 edges
        rst = 1'b1; tick(1); rst = 1'b0;
        ref_v = 0.5;
        for (int k = 0; k < 100; k++) begin
            in_v[0] = 1.0 + 2.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 10.0);
            tick(1);
        end
        chk("lit_sine_rcnt", 0, 0, int'(rc_a[0]), 10);
        chk("lit_sine_sat",  1, 0, int'(rc_b[0]), 3);
        in_v[0] = 0.0;
        tick(4);

        // Hysteresis hold on ch1
        in_v[1] = 0.6;  tick(4);
        in_v[1] = 0.52; tick(5);
        in_v[1] = 0.46; tick(1);
        chk("lit_hyst_hold", 0, 1, int'(raw_a[1]), 1);
        chk("lit_hyst_wide", 1, 1, int'(raw_b[1]), 0);
        in_v[1] = 0.0;  tick(4);

        // Debounce reject/accept on ch2
        rst = 1'b1; tick(1); rst = 1'b0;
        ref_v = 0.0; set_all(-1.0); tick(2);
        in_v[2] = 1.0;  tick(2);
        in_v[2] = -1.0; tick(1);
        chk("lit_deb_reject", 0, 2, int'(out_a[2]), 0);
        tick(2);
        in_v[2] = 1.0;  tick(2);
        chk("lit_deb_e2", 0, 2, int'(out_a[2]), 0);
        tick(1);
        chk("lit_deb_e3",  0, 2, int'(out_a[2]), 1);
        chk("lit_deb_cnt", 0, 2, int'(rc_a[2]), 1);
        in_v[2] = -1.0; tick(4);

        // Saturation and clear-with-rise on ch3
        for (int p = 0; p < 5; p++) begin
            in_v[3] = 1.0;  tick(4);
            in_v[3] = -1.0; tick(4);
        end
        chk("lit_sat",      1, 3, int'(rc_b[3]), 3);
        chk("lit_nosat",    0, 3, int'(rc_a[3]), 5);
        in_v[3] = 1.0; tick(2);
        clr = 1'b1; tick(1); clr = 1'b0;
        chk("lit_clr_rise", 1, 3, int'(rc_b[3]), 1);
        chk("lit_clr_rise", 0, 3, int'(rc_a[3]), 1);
        chk("lit_clr_other", 0, 2, int'(rc_a[2]), 0);
        in_v[3] = -1.0; tick(4);

        // Enable hold while input toggles
        en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_v[0] = (k % 2 == 0) ? 1.0 : -1.0;
            tick(1);
        end
        chk("lit_en_hold", 0, 0, int'(out_a[0]), 0);
        en = 1'b1; in_v[0] = -1.0; tick(4);

        // Reset during a partial debounce run
        in_v[0] = 1.0; tick(2);
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(2);
        chk("lit_rst_mid_e2", 0, 0, int'(out_a[0]), 0);
        tick(1);
        chk("lit_rst_mid_e3", 0, 0, int'(out_a[0]), 1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
